// File: rtl/hazard_pipe_ctrl_if.sv
// Purpose: bundles the ID-stage decode inputs and the pipeline tag/enable outputs of hazard_pipe_ctrl.
// Latency: none, wiring only.
// Backpressure: none carried here; freeze/stall intent travels on PCWrite/IF_ID_Write.
interface hazard_pipe_ctrl_if;
  // ID-stage decode and pipeline-level requests
  logic [4:0]  ID_RegisterRs;
  logic [4:0]  ID_RegisterRt;
  logic        ID_UsesRs;
  logic        ID_UsesRt;
  logic [4:0]  ID_RegisterRd;
  logic        ID_RegWrite;
  logic        ID_MemRead;
  logic        Flush;
  logic        MemBusy;

  // registered tags toward the forwarding unit
  logic [4:0]  ID_EX_RegisterRs;
  logic [4:0]  ID_EX_RegisterRt;
  logic [4:0]  ID_EX_RegisterRd;
  logic        ID_EX_RegWrite;
  logic        ID_EX_MemRead;
  logic [4:0]  EX_MEM_RegisterRd;
  logic        EX_MEM_RegWrite;
  logic        EX_MEM_MemRead;
  logic [4:0]  MEM_WB_RegisterRd;
  logic        MEM_WB_RegWrite;

  // front-end enables and status
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        LoadUseStall;
  logic [15:0] StallCount;

  // datapath / decode side
  modport master (
    output ID_RegisterRs, ID_RegisterRt, ID_UsesRs, ID_UsesRt, ID_RegisterRd,
           ID_RegWrite, ID_MemRead, Flush, MemBusy,
    input  ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd, ID_EX_RegWrite,
           ID_EX_MemRead, EX_MEM_RegisterRd, EX_MEM_RegWrite, EX_MEM_MemRead,
           MEM_WB_RegisterRd, MEM_WB_RegWrite, PCWrite, IF_ID_Write, IF_ID_Flush,
           LoadUseStall, StallCount
  );

  // hazard controller side
  modport slave (
    input  ID_RegisterRs, ID_RegisterRt, ID_UsesRs, ID_UsesRt, ID_RegisterRd,
           ID_RegWrite, ID_MemRead, Flush, MemBusy,
    output ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd, ID_EX_RegWrite,
           ID_EX_MemRead, EX_MEM_RegisterRd, EX_MEM_RegWrite, EX_MEM_MemRead,
           MEM_WB_RegisterRd, MEM_WB_RegWrite, PCWrite, IF_ID_Write, IF_ID_Flush,
           LoadUseStall, StallCount
  );
endinterface

// File: rtl/hazard_pipe_ctrl.sv
// Purpose: carries dest tags/controls through ID/EX, EX/MEM, MEM/WB and resolves load-use, flush and memory-wait hazards.
// Latency: tags reach ID/EX, EX/MEM, MEM/WB 1/2/3 cycles after ID; enables are combinational.
// Backpressure: MemBusy freezes all stages; a load-use hazard holds PC/IF-ID for one cycle and injects a bubble.
module hazard_pipe_ctrl (
  input  logic              clk,
  input  logic              rst,
  hazard_pipe_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    MODE_RESET,
    MODE_FREEZE,
    MODE_FLUSH,
    MODE_BUBBLE,
    MODE_ADVANCE
  } mode_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } id_ex_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } ex_mem_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
  } mem_wb_t;

  mode_e       mode;
  logic        load_use;
  id_ex_t      id_in;
  id_ex_t      id_ex;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;
  logic [15:0] stall_count;

  // Load in EX whose destination matches a source the ID instruction actually reads; r0 never conflicts.
  always_comb begin
    load_use = id_ex.mem_read && (id_ex.rd != 5'd0) &&
               ((bus.ID_UsesRs && (id_ex.rd == bus.ID_RegisterRs)) ||
                (bus.ID_UsesRt && (id_ex.rd == bus.ID_RegisterRt)));
  end

  // Next ID/EX contents from decode; a write to r0 is dropped here so downstream RegWrite implies Rd != 0.
  always_comb begin
    id_in.rs        = bus.ID_RegisterRs;
    id_in.rt        = bus.ID_RegisterRt;
    id_in.rd        = bus.ID_RegisterRd;
    id_in.reg_write = bus.ID_RegWrite && (bus.ID_RegisterRd != 5'd0);
    id_in.mem_read  = bus.ID_MemRead;
  end

  // Pick this cycle's mode by priority and derive the front-end enables from it.
  always_comb begin
    mode             = MODE_ADVANCE;
    bus.PCWrite      = 1'b0;
    bus.IF_ID_Write  = 1'b0;
    bus.IF_ID_Flush  = 1'b0;
    bus.LoadUseStall = 1'b0;
    if (rst) begin
      mode = MODE_RESET;
    end else if (bus.MemBusy) begin
      mode = MODE_FREEZE;
    end else if (bus.Flush) begin
      mode = MODE_FLUSH;
    end else if (load_use) begin
      mode = MODE_BUBBLE;
    end
    case (mode)
      MODE_FLUSH: begin
        bus.PCWrite     = 1'b1;
        bus.IF_ID_Write = 1'b1;
        bus.IF_ID_Flush = 1'b1;
      end
      MODE_BUBBLE: begin
        bus.LoadUseStall = 1'b1;
      end
      MODE_ADVANCE: begin
        bus.PCWrite     = 1'b1;
        bus.IF_ID_Write = 1'b1;
      end
      default: ;
    endcase
  end

  // Pipeline registers: hold on freeze, inject a bubble on flush/load-use, otherwise shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      case (mode)
        MODE_FLUSH, MODE_BUBBLE: begin
          id_ex  <= '0;
          ex_mem <= '{rd: id_ex.rd, reg_write: id_ex.reg_write, mem_read: id_ex.mem_read};
          mem_wb <= '{rd: ex_mem.rd, reg_write: ex_mem.reg_write};
        end
        MODE_ADVANCE: begin
          id_ex  <= id_in;
          ex_mem <= '{rd: id_ex.rd, reg_write: id_ex.reg_write, mem_read: id_ex.mem_read};
          mem_wb <= '{rd: ex_mem.rd, reg_write: ex_mem.reg_write};
        end
        default: ;
      endcase
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= 16'd0;
    end else if (!bus.PCWrite && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  assign bus.ID_EX_RegisterRs  = id_ex.rs;
  assign bus.ID_EX_RegisterRt  = id_ex.rt;
  assign bus.ID_EX_RegisterRd  = id_ex.rd;
  assign bus.ID_EX_RegWrite    = id_ex.reg_write;
  assign bus.ID_EX_MemRead     = id_ex.mem_read;
  assign bus.EX_MEM_RegisterRd = ex_mem.rd;
  assign bus.EX_MEM_RegWrite   = ex_mem.reg_write;
  assign bus.EX_MEM_MemRead    = ex_mem.mem_read;
  assign bus.MEM_WB_RegisterRd = mem_wb.rd;
  assign bus.MEM_WB_RegWrite   = mem_wb.reg_write;
  assign bus.StallCount        = stall_count;

endmodule
